mips_pipeline: RTL and testbench
================================

// Module: mips_pipeline
// PURPOSE
//  5-stage MIPS integer pipeline: IF, ID, EX, MEM, WB. Top-level datapath under test.
//  No instruction memory: the instruction word is driven on a port and captured each cycle.
//  Holds a 32x32 register file, R-type/ADDI decode, ALU and EX forwarding.
//  Write-back is exported on a port so benches can observe results.
// PARAMETERS
//  DATA_W    32  datapath and register width
//  NUM_REGS  32  register-file entries; index width is 5
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  instruction  in   32      instruction word; sampled at every rising clk edge
//  wb_en        out  1       MEM/WB valid write to a nonzero register this cycle
//  wb_addr      out  5       destination register being written
//  wb_data      out  DATA_W  value being written
// BEHAVIOUR
//  Reset (rst_n=0, async): all pipeline registers cleared to NOP (valid=0).
//  - wb_en=0, wb_addr=0, wb_data=0.
//  - Register file r[i]=i for i=0..31.
//  - Deassertion takes effect at the next rising edge.
//  r0 reads 0 always; writes to r0 are dropped (wb_en stays 0).
//  Stage timing, instruction sampled at edge n:
//  - IF/ID latch at n; register read in ID.
//  - ID/EX at n+1; ALU result in EX/MEM at n+2.
//  - MEM/WB at n+3: wb_* valid during the cycle after edge n+3.
//  - Register-file write at edge n+4.
//  Decode, opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]:
//  - op 0: funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT (signed). dest=rd.
//  - op 0x08 ADDI: rt = rs + sign-extended imm[15:0].
//  - Any other opcode or funct, and the all-zero word, is a NOP: no write, no exception.
//  Arithmetic: 32-bit two's complement wrap-around; overflow is ignored (no trap).
//  - SLT yields 1 or 0 in bit 0.
//  MEM is a pass-through stage; there is no data memory.
//  Forwarding into EX operands, priority EX/MEM > MEM/WB > register file:
//  - Applies only when the source write is valid and dest != 0.
//  Register file is write-before-read: an ID read of the register being written at the
//  same edge returns the new value.
//  Result: no stalls are ever needed; back-to-back dependent instructions yield correct results.
//  Reset mid-operation flushes every in-flight instruction; no write occurs for any of them.
// TESTING
//  1 Reset, then hold instruction=0 for 8 cycles -> wb_en stays 0; r[i]=i.
//  2 0x00E91020 (ADD r2,r7,r9) -> 4 cycles later wb_en=1, wb_addr=2, wb_data=16.
//  3 0x00E91020 then 0x004A1822 (SUB r3,r2,r10) on consecutive cycles
//    -> r2=16, then r3=6 (EX/MEM forward).
//  4 ADD r2, NOP, SUB r3,r2,r10 -> r3=6 (MEM/WB forward);
//    with 2 NOPs between -> r3=6 (write-before-read).
//  5 ADDI r4,r0,-1 (0x2004FFFF); SLT r5,r4,r1 -> r4=0xFFFFFFFF, r5=1;
//    ADD r0,r7,r9 -> wb_en=0.
//  6 Assert rst_n low mid-stream with 3 instructions in flight -> wb_en=0 immediately;
//    no writes after release; r2 reads 2.

Source files
------------

// File: rtl/mips_pipeline_if.sv
// Instruction-in / write-back-out bundle for the pipeline.
//   instruction : instruction word captured each rising clk edge
//   wb_en       : a write to a nonzero register is in MEM/WB this cycle
//   wb_addr     : destination register of that write
//   wb_data     : value being written
// master = instruction source / write-back observer, slave = pipeline.
interface mips_pipeline_if #(
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_AW  = 5;

    logic [INSTR_W-1:0] instruction;
    logic               wb_en;
    logic [REG_AW-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;

    modport master (
        output instruction,
        input  wb_en,
        input  wb_addr,
        input  wb_data
    );

    modport slave (
        input  instruction,
        output wb_en,
        output wb_addr,
        output wb_data
    );
endinterface

// File: rtl/mips_pipeline.sv
// 5-stage MIPS integer pipeline (IF, ID, EX, MEM, WB) without memories.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; flushes all stages, reloads r[i]=i
//   bus   : slave side of mips_pipeline_if (instruction in, write-back out)
// Supports ADD/SUB/AND/OR/NOR/SLT (R-type) and ADDI; everything else is a NOP.
// Full forwarding (EX/MEM, MEM/WB) plus a write-before-read register file
// means dependent instructions never stall.
module mips_pipeline #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mips_pipeline_if.slave   bus
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_AW  = $clog2(NUM_REGS);
    localparam int unsigned OP_W    = 6;
    localparam int unsigned IMM_W   = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    // Pipeline registers
    logic [INSTR_W-1:0] if_id_instr;

    logic               id_ex_wr;
    logic [2:0]         id_ex_alu;
    logic               id_ex_use_imm;
    logic [REG_AW-1:0]  id_ex_rs;
    logic [REG_AW-1:0]  id_ex_rt;
    logic [DATA_W-1:0]  id_ex_rs_val;
    logic [DATA_W-1:0]  id_ex_rt_val;
    logic [DATA_W-1:0]  id_ex_imm;
    logic [REG_AW-1:0]  id_ex_dest;

    logic               ex_mem_wr;
    logic [REG_AW-1:0]  ex_mem_dest;
    logic [DATA_W-1:0]  ex_mem_result;

    logic               mem_wb_wr;
    logic [REG_AW-1:0]  mem_wb_dest;
    logic [DATA_W-1:0]  mem_wb_result;

    logic [DATA_W-1:0]  regs [NUM_REGS];

    // ID-stage decode and register read
    logic [OP_W-1:0]    id_op_c;
    logic [5:0]         id_funct_c;
    logic [REG_AW-1:0]  id_rs_c;
    logic [REG_AW-1:0]  id_rt_c;
    logic [REG_AW-1:0]  id_rd_c;
    logic               id_valid_c;
    logic               id_wr_c;
    logic [2:0]         id_alu_c;
    logic               id_use_imm_c;
    logic [REG_AW-1:0]  id_dest_c;
    logic [DATA_W-1:0]  id_imm_c;
    logic [DATA_W-1:0]  id_rs_val_c;
    logic [DATA_W-1:0]  id_rt_val_c;

    // EX-stage operands and result
    logic [DATA_W-1:0]  ex_a_c;
    logic [DATA_W-1:0]  ex_rt_fwd_c;
    logic [DATA_W-1:0]  ex_b_c;
    logic [DATA_W-1:0]  ex_result_c;

    assign id_op_c    = if_id_instr[31:26];
    assign id_rs_c    = if_id_instr[25:21];
    assign id_rt_c    = if_id_instr[20:16];
    assign id_rd_c    = if_id_instr[15:11];
    assign id_funct_c = if_id_instr[5:0];
    assign id_imm_c   = DATA_W'($signed(if_id_instr[IMM_W-1:0]));

    // Instruction decode; unrecognised encodings fall through as NOPs
    always_comb begin
        id_valid_c   = 1'b0;
        id_alu_c     = ALU_ADD;
        id_use_imm_c = 1'b0;
        id_dest_c    = id_rd_c;
        case (id_op_c)
            OP_RTYPE: begin
                id_valid_c = 1'b1;
                case (id_funct_c)
                    FN_ADD:  id_alu_c = ALU_ADD;
                    FN_SUB:  id_alu_c = ALU_SUB;
                    FN_AND:  id_alu_c = ALU_AND;
                    FN_OR:   id_alu_c = ALU_OR;
                    FN_NOR:  id_alu_c = ALU_NOR;
                    FN_SLT:  id_alu_c = ALU_SLT;
                    default: id_valid_c = 1'b0;
                endcase
            end
            OP_ADDI: begin
                id_valid_c   = 1'b1;
                id_use_imm_c = 1'b1;
                id_dest_c    = id_rt_c;
            end
            default: id_valid_c = 1'b0;
        endcase
        // r0 destinations never produce a write, so they never forward either
        id_wr_c = id_valid_c && (id_dest_c != '0);
    end

    // Register read with write-before-read bypass from the write-back stage
    always_comb begin
        id_rs_val_c = regs[id_rs_c];
        id_rt_val_c = regs[id_rt_c];
        if (mem_wb_wr && (mem_wb_dest == id_rs_c)) id_rs_val_c = mem_wb_result;
        if (mem_wb_wr && (mem_wb_dest == id_rt_c)) id_rt_val_c = mem_wb_result;
        if (id_rs_c == '0) id_rs_val_c = '0;
        if (id_rt_c == '0) id_rt_val_c = '0;
    end

    // EX operand forwarding: EX/MEM wins over MEM/WB, which wins over ID/EX copy
    always_comb begin
        ex_a_c = id_ex_rs_val;
        if (ex_mem_wr && (ex_mem_dest == id_ex_rs))      ex_a_c = ex_mem_result;
        else if (mem_wb_wr && (mem_wb_dest == id_ex_rs)) ex_a_c = mem_wb_result;

        ex_rt_fwd_c = id_ex_rt_val;
        if (ex_mem_wr && (ex_mem_dest == id_ex_rt))      ex_rt_fwd_c = ex_mem_result;
        else if (mem_wb_wr && (mem_wb_dest == id_ex_rt)) ex_rt_fwd_c = mem_wb_result;

        ex_b_c = id_ex_use_imm ? id_ex_imm : ex_rt_fwd_c;
    end

    // ALU; arithmetic wraps silently
    always_comb begin
        ex_result_c = '0;
        case (id_ex_alu)
            ALU_ADD: ex_result_c = ex_a_c + ex_b_c;
            ALU_SUB: ex_result_c = ex_a_c - ex_b_c;
            ALU_AND: ex_result_c = ex_a_c & ex_b_c;
            ALU_OR:  ex_result_c = ex_a_c | ex_b_c;
            ALU_NOR: ex_result_c = ~(ex_a_c | ex_b_c);
            ALU_SLT: ex_result_c = DATA_W'($signed(ex_a_c) < $signed(ex_b_c));
            default: ex_result_c = '0;
        endcase
    end

    // Pipeline stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr   <= '0;
            id_ex_wr      <= 1'b0;
            id_ex_alu     <= ALU_ADD;
            id_ex_use_imm <= 1'b0;
            id_ex_rs      <= '0;
            id_ex_rt      <= '0;
            id_ex_rs_val  <= '0;
            id_ex_rt_val  <= '0;
            id_ex_imm     <= '0;
            id_ex_dest    <= '0;
            ex_mem_wr     <= 1'b0;
            ex_mem_dest   <= '0;
            ex_mem_result <= '0;
            mem_wb_wr     <= 1'b0;
            mem_wb_dest   <= '0;
            mem_wb_result <= '0;
        end else begin
            if_id_instr   <= bus.instruction;
            id_ex_wr      <= id_wr_c;
            id_ex_alu     <= id_alu_c;
            id_ex_use_imm <= id_use_imm_c;
            id_ex_rs      <= id_rs_c;
            id_ex_rt      <= id_rt_c;
            id_ex_rs_val  <= id_rs_val_c;
            id_ex_rt_val  <= id_rt_val_c;
            id_ex_imm     <= id_imm_c;
            id_ex_dest    <= id_dest_c;
            ex_mem_wr     <= id_ex_wr;
            ex_mem_dest   <= id_ex_dest;
            ex_mem_result <= ex_result_c;
            mem_wb_wr     <= ex_mem_wr;
            mem_wb_dest   <= ex_mem_dest;
            mem_wb_result <= ex_mem_result;
        end
    end

    // Register file: reset image is r[i]=i; r0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (mem_wb_wr) begin
            regs[mem_wb_dest] <= mem_wb_result;
        end
    end

    assign bus.wb_en   = mem_wb_wr;
    assign bus.wb_addr = mem_wb_dest;
    assign bus.wb_data = mem_wb_result;

endmodule

// File: tb/tb_mips_pipeline.sv
// Directed bench for mips_pipeline: a driver issues instructions and queues the
// expected write-back; a negedge monitor compares every cycle against the queue.
module tb_mips_pipeline;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
        int                due;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    wb_exp_t q[$];

    mips_pipeline_if #(.DATA_W(DATA_W)) bus ();

    mips_pipeline #(.DATA_W(DATA_W), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: expected write-back for this cycle comes only from the queue
    always @(negedge clk) begin
        logic    exp_en;
        wb_exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            tests++; fails++;
            $display("FAIL missed_wb: r%0d=%h due cycle %0d never written", e.addr, e.data, e.due);
        end
        exp_en = rst_n && (q.size() > 0) && (q[0].due == cyc);
        tests++;
        if (bus.wb_en !== exp_en) begin
            fails++;
            $display("FAIL wb_en cycle %0d: got %b expected %b", cyc, bus.wb_en, exp_en);
        end
        if (exp_en) begin
            e = q.pop_front();
            tests++;
            if (bus.wb_addr !== e.addr) begin
                fails++;
                $display("FAIL wb_addr cycle %0d: got %0d expected %0d", cyc, bus.wb_addr, e.addr);
            end
            tests++;
            if (bus.wb_data !== e.data) begin
                fails++;
                $display("FAIL wb_data r%0d cycle %0d: got %h expected %h", e.addr, cyc, bus.wb_data, e.data);
            end
        end else if (!rst_n) begin
            tests++;
            if (bus.wb_addr !== 5'd0 || bus.wb_data !== '0) begin
                fails++;
                $display("FAIL reset_wb cycle %0d: got addr %0d data %h expected 0/0", cyc, bus.wb_addr, bus.wb_data);
            end
        end
    end

    // Drive one instruction for the next rising edge; queue its write if any
    task automatic issue(input logic [31:0] ins, input bit wr,
                         input logic [4:0] a, input logic [DATA_W-1:0] d);
        wb_exp_t e;
        @(negedge clk);
        bus.instruction = ins;
        if (wr) begin
            e.addr = a;
            e.data = d;
            e.due  = cyc + 4;
            q.push_back(e);
        end
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(32'h0, 1'b0, 5'd0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.instruction = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: no write-back
        nops(8);

        // Single ADD r2,r7,r9 = 16
        issue(32'h00E91020, 1'b1, 5'd2, 32'd16);
        nops(6);

        // EX/MEM forward
        issue(32'h00E91020, 1'b1, 5'd2, 32'd16);
        issue(32'h004A1822, 1'b1, 5'd3, 32'd6);
        nops(6);

        // MEM/WB forward
        issue(32'h00E91020, 1'b1, 5'd2, 32'd16);
        nops(1);
        issue(32'h004A1822, 1'b1, 5'd3, 32'd6);
        nops(6);

        // Write-before-read
        issue(32'h00E91020, 1'b1, 5'd2, 32'd16);
        nops(2);
        issue(32'h004A1822, 1'b1, 5'd3, 32'd6);
        nops(6);

        // ADDI with negative immediate, signed SLT, r0 destination dropped
        issue(32'h2004FFFF, 1'b1, 5'd4, 32'hFFFF_FFFF);
        issue(32'h0081282A, 1'b1, 5'd5, 32'd1);
        issue(32'h00E90020, 1'b0, 5'd0, '0);
        issue(32'h00E93024, 1'b1, 5'd6, 32'd1);           // AND r6,r7,r9
        issue(32'h00E94025, 1'b1, 5'd8, 32'd15);          // OR r8,r7,r9
        issue(32'h00E95827, 1'b1, 5'd11, 32'hFFFF_FFF0);  // NOR r11,r7,r9
        issue(32'h0024602A, 1'b1, 5'd12, 32'd0);          // SLT r12,r1,r4
        issue(32'h208D0005, 1'b1, 5'd13, 32'd4);          // ADDI r13,r4,5
        issue(32'h00847020, 1'b1, 5'd14, 32'hFFFF_FFFE);  // ADD r14,r4,r4 wraps
        issue(32'h00E91021, 1'b0, 5'd0, '0);              // unsupported funct
        issue(32'h8CE20000, 1'b0, 5'd0, '0);              // unsupported opcode
        nops(6);

        // Reset with three instructions in flight: none may write
        issue(32'h00E91020, 1'b0, 5'd0, '0);
        issue(32'h004A1822, 1'b0, 5'd0, '0);
        issue(32'h2004FFFF, 1'b0, 5'd0, '0);
        nops(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.wb_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_immediate: got wb_en %b expected 0", bus.wb_en);
        end
        bus.instruction = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Register file restored: r2=2, r4=4
        issue(32'h00403020, 1'b1, 5'd6, 32'd2);  // ADD r6,r2,r0
        issue(32'h00803820, 1'b1, 5'd7, 32'd4);  // ADD r7,r4,r0
        nops(8);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
